// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared PISO shifter with an idle gap between frames.
// Optional even-parity trailer bit enabled by defining PISO_ARB_PARITY_EN.
module piso_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       serial_out,
  output logic                       serial_valid,
  output logic                       serial_last,
  output logic [$clog2(NUM_REQ)-1:0] cur_src,
  output logic                       busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_ARB_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [3:0] GAP_LOAD =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [FL-1:0]   r_sh;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gap;

  logic            w_found;
  logic [PW-1:0]   w_win;
  int              w_idx;
  logic [WIDTH-1:0] w_word;
  logic [FL-1:0]   w_frame;

  // First set request searching upward from the slot after the last grant
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  // Winner's word, plus the parity trailer when that option is built in
  always_comb begin
    w_word = data_in[w_win*WIDTH +: WIDTH];
`ifdef PISO_ARB_PARITY_EN
    w_frame = {w_word, ^w_word};
`else
    w_frame = w_word;
`endif
  end

  // Control FSM: grant, shift out MSB first, then hold the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= PW'(NUM_REQ - 1);
      r_sh         <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      ack          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      serial_last  <= 1'b0;
      cur_src      <= '0;
      busy         <= 1'b0;
    end else begin
      ack <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_SHIFT;
            r_sh         <= w_frame;
            r_cnt        <= CW'(FL - 1);
            r_ptr        <= w_win;
            ack          <= NUM_REQ'(1) << w_win;
            cur_src      <= w_win;
            serial_out   <= w_frame[FL-1];
            serial_valid <= 1'b1;
            serial_last  <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_sh        <= r_sh << 1;
            r_cnt       <= r_cnt - 1'b1;
            serial_out  <= r_sh[FL-2];
            serial_last <= (r_cnt == CW'(1));
          end else begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_gap   <= GAP_LOAD;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
- Shares one parallel-in/serial-out shifter between NUM_REQ requesters.
- Each requester presents a WIDTH-bit word with a request.
- The block arbitrates round-robin, captures the granted word, and shifts it out MSB-first with a valid strobe.
- It then inserts a programmable idle gap before the next frame. It sits between parallel producers and a single serial link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, bits per word (>=2)
- GAP_CYCLES, 1, idle cycles forced after each frame (0..15)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level
- data_in  input  NUM_REQ*WIDTH  word for requester i at bits [i*WIDTH +: WIDTH]
- ack  output  NUM_REQ  one-cycle, one-hot pulse; word captured
- serial_out  output  1  serial data bit, MSB first
- serial_valid  output  1  serial_out carries a frame bit
- serial_last  output  1  final bit of the current frame
- cur_src  output  clog2(NUM_REQ)  index of the requester being transmitted
- busy  output  1  frame or gap in progress

Behaviour:
- Reset:
  - rst_n low clears all outputs and internal state to 0 immediately.
  - The round-robin pointer resets to NUM_REQ-1, so req[0] has first priority.
- All outputs are registered.
- States:
  - IDLE -> SHIFT: in IDLE, if any req bit is high at edge T, the winner is the first set bit searching from pointer+1 mod NUM_REQ. At that edge:
    - state becomes SHIFT
    - the winner's word is captured
    - ack[winner]=1 for cycle T+1 only
    - cur_src=winner
    - pointer=winner
  - SHIFT: serial_valid=1 for cycles T+1..T+WIDTH. serial_out carries data bits WIDTH-1 down to 0, one per cycle. serial_last=1 only in cycle T+WIDTH. After the last bit:
    - go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: serial_valid=0 and serial_out=0 for GAP_CYCLES cycles, then IDLE.
  - IDLE itself lasts at least one cycle. Minimum spacing between frames is therefore GAP_CYCLES+1 invalid cycles.
- busy=1 in SHIFT and GAP, 0 in IDLE.
- cur_src holds its value until the next grant.
- serial_out=0 whenever serial_valid=0.
- req is sampled only in IDLE:
  - A req dropped before being granted is lost without ack.
  - A req still high after its ack is treated as a new request at the next IDLE.
  - Requesters must hold data_in stable while req is high and un-acked.
- Simultaneous requests: exactly one grant per IDLE decision. The others wait; no starvation, since each requester is reached within NUM_REQ frames.
- Reset mid-frame aborts the frame immediately:
  - no serial_last, no further bits
  - the pointer returns to NUM_REQ-1
- Frames after reset always start from bit WIDTH-1.
- Internal bit counter width is clog2(WIDTH+1). The gap counter is 4 bits.

Optional Feature:
- PISO_ARB_PARITY_EN
- Defined: after the WIDTH data bits, one extra bit carrying even parity (XOR of the word) is sent in cycle T+WIDTH+1 with serial_valid=1. serial_last moves to that bit. GAP follows the parity bit.
- Undefined: no parity bit is sent and the frame is exactly WIDTH bits.

Test Plan (NUM_REQ=4, WIDTH=4, GAP_CYCLES=1, parity off unless stated):
- Assert rst_n=0 mid-run with req active -> all outputs 0 during reset; first grant after release goes to req[0] if requested.
- req[1]=1, data 4'b1011 at edge T -> ack[1] in T+1; serial_out 1,0,1,1 with serial_valid high at T+1..T+4; serial_last only at T+4; cur_src=1; busy T+1..T+5.
- req[3:0]=4'b1111 held, each dropped after its ack -> grants in order 0,1,2,3; two invalid cycles between frames; exactly one ack per frame.
- req[0] and req[2] held continuously -> grants alternate 0,2,0,2; req[1], req[3] never acked.
- rst_n low during the third bit of a frame from req[2] -> serial_valid drops immediately, no serial_last; after release the held req[2] is re-sent in full starting at MSB.
- PISO_ARB_PARITY_EN defined, data 4'b1011 -> bits 1,0,1,1,1 at T+1..T+5; serial_last at T+5; next frame bits no earlier than T+8.
